// File: rtl/vga_mon_pkg.sv
// vga_mon_pkg: shared state encoding and default sizing for the VGA timing monitor
package vga_mon_pkg;
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
  localparam int CNT_W_DEF = 16;
  localparam int SUM_W_DEF = 24;
  localparam int LOCK_FRAMES_DEF = 2;
  localparam int RGB_W = 3;
  localparam int MATCH_W = 4;
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: delays an active-low sync, flags its edges and measures its low width
module vga_sync_edge import vga_mon_pkg::*; #(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_sync,
  input  logic         i_en,
  output logic         o_fall,
  output logic         o_rise,
  output logic [W-1:0] o_lo
);
  logic         r_d;
  logic [W-1:0] r_lo;
  assign o_fall = r_d & ~i_sync;
  assign o_rise = ~r_d & i_sync;
  assign o_lo   = r_lo;
  // i_en tied high counts clocks; driven by line strobes it counts lines
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d  <= 1'b0;
      r_lo <= '0;
    end else begin
      r_d <= i_sync;
      if (o_fall) r_lo <= {{(W-1){1'b0}}, i_en};
      else if (!i_sync && i_en) r_lo <= r_lo + 1'b1;
    end
  end
endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers VGA line/frame timing, checksums frames and tracks lock
module vga_timing_monitor import vga_mon_pkg::*; #(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SUM_W       = SUM_W_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [RGB_W-1:0] rgb,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_sync_w,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_sync_w,
  output logic [SUM_W-1:0] frame_sum,
  output logic [15:0]      frame_cnt,
  output logic             frame_done,
  output logic             locked,
  output logic             lock_lost
);
  logic               w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
  logic [CNT_W-1:0]   w_hs_lo, w_vs_lo, w_h_nx, w_v_nx;
  logic [CNT_W-1:0]   r_h_cnt, r_v_cnt;
  logic [SUM_W-1:0]   r_acc;
  logic               r_bad, w_line_bad, w_good, w_timeout, w_lost;
  logic [MATCH_W-1:0] r_match, w_match_nx, w_match_inc;
  state_t             r_state, w_state_nx;
  vga_sync_edge #(.W(CNT_W)) u_hs (
    .clk(clk), .reset(reset), .i_sync(hsync), .i_en(1'b1),
    .o_fall(w_hs_fall), .o_rise(w_hs_rise), .o_lo(w_hs_lo)
  );
  vga_sync_edge #(.W(CNT_W)) u_vs (
    .clk(clk), .reset(reset), .i_sync(vsync), .i_en(w_hs_fall),
    .o_fall(w_vs_fall), .o_rise(w_vs_rise), .o_lo(w_vs_lo)
  );
  // a line ending on the vsync fall still belongs to the frame being closed
  assign w_h_nx      = r_h_cnt + 1'b1;
  assign w_v_nx      = r_v_cnt + CNT_W'(w_hs_fall);
  assign w_line_bad  = w_hs_fall && (w_h_nx != h_total);
  assign w_good      = !r_bad && !w_line_bad && (w_v_nx == v_total);
  assign w_timeout   = (&r_h_cnt) && !w_hs_fall;
  assign w_match_inc = r_match + 1'b1;
  assign locked      = r_state == LOCKED;
  always_comb begin
    w_state_nx = r_state;
    w_match_nx = r_match;
    w_lost     = 1'b0;
    if (w_vs_fall) begin
      if (r_state == SEARCH) begin
        w_state_nx = CHECK;
        w_match_nx = '0;
      end else if (r_state == CHECK) begin
        w_match_nx = w_good ? w_match_inc : '0;
        w_state_nx = (w_good && w_match_inc == MATCH_W'(LOCK_FRAMES)) ? LOCKED : CHECK;
      end else if (!w_good) begin
        w_state_nx = SEARCH;
        w_lost     = 1'b1;
      end
    end
    if (w_timeout) begin
      w_state_nx = SEARCH;
      w_lost     = r_state == LOCKED;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_acc      <= '0;
      r_bad      <= 1'b0;
      r_match    <= '0;
      r_state    <= SEARCH;
      h_total    <= '0;
      h_sync_w   <= '0;
      v_total    <= '0;
      v_sync_w   <= '0;
      frame_sum  <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      if (w_hs_fall) begin
        h_total <= w_h_nx;
        r_h_cnt <= '0;
      end else if (!(&r_h_cnt)) r_h_cnt <= w_h_nx;
      if (w_hs_rise) h_sync_w <= w_hs_lo;
      if (w_vs_rise) v_sync_w <= w_vs_lo;
      if (w_vs_fall) r_bad <= 1'b0;
      else if (w_line_bad) r_bad <= 1'b1;
      if (w_vs_fall) begin
        v_total   <= w_v_nx;
        r_v_cnt   <= '0;
        frame_sum <= r_acc;
        r_acc     <= SUM_W'(rgb);
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        if (w_hs_fall) r_v_cnt <= r_v_cnt + 1'b1;
        r_acc <= r_acc + SUM_W'(rgb);
      end
      frame_done <= w_vs_fall;
      lock_lost  <= w_lost;
      r_state    <= w_state_nx;
      r_match    <= w_match_nx;
    end
  end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: randomized raster stimulus against an event-level timing model
module tb_vga_timing_monitor;
  localparam int LF = 2;
  logic        clk = 1'b0, reset = 1'b1, hsync = 1'b1, vsync = 1'b1;
  logic [2:0]  rgb = 3'd0;
  logic [15:0] h_total, h_sync_w, v_total, v_sync_w, frame_cnt;
  logic [23:0] frame_sum;
  logic        frame_done, locked, lock_lost;
  vga_timing_monitor #(.CNT_W(16), .SUM_W(24), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .h_total(h_total), .h_sync_w(h_sync_w), .v_total(v_total), .v_sync_w(v_sync_w),
    .frame_sum(frame_sum), .frame_cnt(frame_cnt), .frame_done(frame_done),
    .locked(locked), .lock_lost(lock_lost)
  );
  always #5 clk = ~clk;
  typedef struct {int unsigned vt, fs, fc, ht, hw, vw;} rec_t;
  rec_t   q[$];
  int     checks = 0, errors = 0, ll_seen = 0;
  longint now = 0, last_hf = 0, hlo_start = 1;
  int     m_ht = 0, m_hw = 0, m_vt = 0, m_vw = 0, m_fs = 0, m_fc = 0;
  int     acc = 0, lines = 0, vl = 0, streak = 0;
  bit     prev_h = 0, prev_v = 0, frame_ok = 1, armed = 0, m_locked = 0, e_ll = 0, e_fd = 0;
  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // timing derived from edge timestamps and per-frame tallies
  task automatic model_step(bit r, bit h, bit v, int c);
    bit hf, hr, vf, vr, line_ok, good, tmo;
    longint k;
    int hc, hv, tot;
    e_ll = 0;
    e_fd = 0;
    if (r) begin
      prev_h = 0; prev_v = 0; last_hf = now; hlo_start = now + 1;
      m_ht = 0; m_hw = 0; m_vt = 0; m_vw = 0; m_fs = 0; m_fc = 0;
      acc = 0; lines = 0; vl = 0; frame_ok = 1; armed = 0; streak = 0; m_locked = 0;
      now++;
      return;
    end
    hf = prev_h && !h;
    hr = !prev_h && h;
    vf = prev_v && !v;
    vr = !prev_v && v;
    k = now - last_hf;
    line_ok = 1;
    tmo = !hf && k >= 65536;
    if (hf) begin
      hc = (k - 1 > 65535) ? 65535 : int'(k - 1);
      hv = (hc + 1) % 65536;
      line_ok = (hv == m_ht);
      m_ht = hv;
      last_hf = now;
      hlo_start = now;
    end
    if (hr) m_hw = int'((now - hlo_start) % 65536);
    if (vr) m_vw = vl;
    if (vf) vl = int'(hf);
    else if (!v && hf) vl++;
    if (vf) begin
      tot = lines + int'(hf);
      good = frame_ok && line_ok && tot == m_vt;
      m_vt = tot; lines = 0; frame_ok = 1; m_fs = acc; acc = c;
      m_fc = (m_fc + 1) % 65536;
      e_fd = 1;
      if (!armed) begin
        armed = 1;
        streak = 0;
      end else if (m_locked) begin
        if (!good) begin m_locked = 0; armed = 0; e_ll = 1; end
      end else if (good) begin
        streak++;
        if (streak == LF) m_locked = 1;
      end else streak = 0;
      q.push_back('{m_vt, m_fs, m_fc, m_ht, m_hw, m_vw});
    end else begin
      if (hf) lines++;
      if (!line_ok) frame_ok = 0;
      acc = (acc + c) % (1 << 24);
    end
    if (tmo) begin
      if (m_locked) e_ll = 1;
      m_locked = 0; armed = 0; streak = 0;
    end
    prev_h = h;
    prev_v = v;
    now++;
  endtask
  task automatic tick(bit r, bit h, bit v, logic [2:0] c);
    @(negedge clk);
    reset = r; hsync = h; vsync = v; rgb = c;
    model_step(r, h, v, int'(c));
  endtask
  task automatic send_frame(int long_l, bit rnd);
    for (int ln = 0; ln < 6; ln++)
      for (int cc = 0; cc < ((ln == long_l) ? 11 : 10); cc++)
        tick(0, cc >= 2, ln >= 2, rnd ? 3'($urandom_range(0, 7)) : 3'd5);
  endtask
  always @(posedge clk) begin
    rec_t e;
    #1;
    chk("locked", locked, m_locked);
    chk("lock_lost", lock_lost, e_ll);
    chk("frame_done", frame_done, e_fd);
    if (lock_lost) ll_seen++;
    if (frame_done) begin
      if (q.size() == 0) chk("frame_done_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("v_total", v_total, e.vt);
        chk("frame_sum", frame_sum, e.fs);
        chk("frame_cnt", frame_cnt, e.fc);
        chk("h_total", h_total, e.ht);
        chk("h_sync_w", h_sync_w, e.hw);
        chk("v_sync_w", v_sync_w, e.vw);
      end
    end
  end
  initial begin
    repeat (2) tick(1, 1, 1, 0);
    repeat (5) tick(0, 1, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      send_frame(-1, 0);
      if (i == 3) chk("locked_after_3", locked, 0);
    end
    chk("locked_after_4", locked, 1);
    chk("frame_cnt_4", frame_cnt, 4);
    send_frame(-1, 0);
    chk("nom_h_total", h_total, 10);
    chk("nom_h_sync_w", h_sync_w, 2);
    chk("nom_v_total", v_total, 6);
    chk("nom_v_sync_w", v_sync_w, 2);
    chk("nom_frame_sum", frame_sum, 300);
    chk("nom_frame_cnt", frame_cnt, 5);
    repeat (3) send_frame(-1, 1);
    send_frame($urandom_range(0, 3), 1);
    chk("locked_before_loss", locked, 1);
    send_frame(-1, 1);
    chk("locked_after_loss", locked, 0);
    chk("lock_lost_count", ll_seen, 1);
    repeat (2) send_frame(-1, 1);
    chk("relock_pending", locked, 0);
    send_frame(-1, 1);
    chk("relocked", locked, 1);
    repeat (2) tick(0, 0, 1, 3'($urandom_range(0, 7)));
    repeat (65540) tick(0, 1, 1, 3'($urandom_range(0, 7)));
    chk("timeout_locked", locked, 0);
    chk("timeout_h_total", h_total, 10);
    chk("timeout_lock_lost", ll_seen, 2);
    repeat (4) send_frame(-1, 1);
    chk("relock_after_timeout", locked, 1);
    for (int c = 0; c < 25; c++) tick(0, (c % 10) >= 2, c >= 20, 3'd5);
    tick(1, 1, 1, 3'd5);
    tick(0, 1, 1, 3'd0);
    chk("rst_h_total", h_total, 0);
    chk("rst_h_sync_w", h_sync_w, 0);
    chk("rst_v_total", v_total, 0);
    chk("rst_v_sync_w", v_sync_w, 0);
    chk("rst_frame_sum", frame_sum, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lock_lost", lock_lost, 0);
    repeat (3) tick(0, 1, 1, 3'd0);
    for (int i = 1; i <= 4; i++) begin
      send_frame(-1, 1);
      if (i == 3) chk("rst_locked_after_3", locked, 0);
    end
    chk("rst_locked_after_4", locked, 1);
    repeat (3) tick(0, 1, 1, 3'd0);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receiving end of the VGA raster interface: consumes the hsync, vsync and rgb outputs of a pattern generator built on hvsync_generator.
- Recovers line and frame timing, measures sync pulse widths and computes a per-frame rgb checksum.
- Declares lock once timing is stable.
- Used in simulation benches and on-chip loopback to check generator timing without a monitor.

Parameters:
- CNT_W, 16, width of cycle/line counters and all measurement outputs.
- SUM_W, 24, width of frame rgb checksum accumulator (wraps modulo 2^SUM_W).
- LOCK_FRAMES, 2, consecutive good frames required to assert locked (1..15).

Ports:
- clk  input  1  clock; inputs are synchronous to it (same clock domain as generator).
- reset  input  1  synchronous, active-high reset.
- hsync  input  1  horizontal sync, active-low.
- vsync  input  1  vertical sync, active-low.
- rgb  input  3  pixel colour {r,g,b}.
- h_total  output  CNT_W  clocks per line (hsync fall to next fall).
- h_sync_w  output  CNT_W  clocks hsync held low.
- v_total  output  CNT_W  lines per frame (hsync falls between vsync falls).
- v_sync_w  output  CNT_W  hsync falls while vsync low.
- frame_sum  output  SUM_W  sum of rgb (0..7, zero-extended) over the last complete frame.
- frame_cnt  output  16  completed frames since reset, wraps.
- frame_done  output  1  one-cycle strobe: v_total/frame_sum/frame_cnt just updated.
- locked  output  1  timing stable.
- lock_lost  output  1  one-cycle strobe on LOCKED->SEARCH.

Behaviour:
- Reset (synchronous): all outputs, counters, the hs_d/vs_d registers and match_cnt = 0; state = SEARCH.
- Edge detect: hs_d/vs_d = input delayed 1 clock. hs_fall = hs_d & ~hsync; hs_rise = ~hs_d & hsync (same for vsync). Edge in cycle t -> registered outputs update at end of t (visible at t+1).
- Line counter h_cnt:
  - hs_fall: h_total <= h_cnt+1; h_cnt <= 0.
  - Else h_cnt <= h_cnt+1, saturating at all-ones.
  - At saturation: timeout. State -> SEARCH; locked = 0; lock_lost pulses if state was LOCKED.
- Hsync width: hs_fall sets hs_lo = 1; hs_lo increments while hsync low; hs_rise: h_sync_w <= hs_lo.
- Line check: on hs_fall, if h_cnt+1 != h_total, set frame_bad. frame_bad is cleared at vsync fall.
- Line count v_cnt:
  - vsync fall: v_total <= v_cnt + hs_fall; v_cnt <= 0; frame_done = 1.
  - Else v_cnt increments on hs_fall.
- Vsync width: vsync fall sets vs_lines = 0 (1 if hs_fall same cycle); increments on hs_fall while vsync low; vsync rise: v_sync_w <= vs_lines.
- Checksum:
  - vsync fall: frame_sum <= acc; acc <= rgb.
  - Else acc <= acc + rgb.
  - frame_cnt increments on vsync fall.
- A vsync fall is "good" when frame_bad==0 AND v_cnt+hs_fall == v_total (old value).
- FSM, evaluated on vsync fall only:
  - SEARCH -> CHECK, match_cnt <= 0.
  - CHECK: good -> match_cnt+1; reaching LOCKED_FRAMES -> LOCKED (locked high next cycle). Not good -> match_cnt <= 0, stay.
  - LOCKED: not good -> SEARCH, locked <= 0, lock_lost pulse.
  - Timeout overrides from any state.
- Startup: the first vsync fall enters CHECK. The second compares against a partial frame and fails. With LOCK_FRAMES=2, locked rises after the 4th vsync fall.
- Simultaneous hs_fall and vsync fall: the line counts toward the ending frame.

Decomposition:
- Package vga_mon_pkg:
  - state enum {SEARCH, CHECK, LOCKED}.
  - Default CNT_W, SUM_W, LOCK_FRAMES constants.
  - RGB width constant (3).
- Sub-module vga_sync_edge (one instance per sync), outputs:
  - registered delay
  - fall/rise strobes
  - low-width counter (clocks or gated by an enable for lines)

Test Plan:
- Stimulus timing for all scenarios: line = 10 clocks, hsync low 2 clocks; frame = 6 lines, vsync low 2 lines; rgb constant 3'b101.
- Nominal -> after the 2nd vsync fall: h_total=10, h_sync_w=2, v_total=6, v_sync_w=2, frame_sum=300; frame_done one cycle per frame.
- Lock sequence -> locked=0 through the 3rd vsync fall; locked=1 from the cycle after the 4th; frame_cnt=4.
- While locked, make one line 11 clocks -> at the next vsync fall: locked=0 and lock_lost=1 for one cycle. Relock after 3 further clean frames.
- Hold hsync high for 65535 clocks -> timeout; locked=0; h_total unchanged.
- Assert reset mid-frame for 1 clock -> all outputs 0 the next cycle; state SEARCH; relock takes 4 vsync falls again.
